mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arbiter_2.sv | 34 +++
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter: requester ids and
// the one-entry read response tag.
package mem_arb_pkg;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LS    = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rsp_tag_t;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_FETCH) ? REQ_LS : REQ_FETCH;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer moves to
// the loser after every grant and holds when nothing is granted.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (ptr_q == REQ_LS) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_LS;
    end else if (gnt != 2'b00) begin
      ptr_q <= other_req(gnt[1] ? REQ_LS : REQ_FETCH);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, with
// round-robin grants and one-cycle read data routed by a response tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_fetch_req,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic                  o_fetch_gnt,
  output logic                  o_fetch_rvalid,
  output logic [DATA_WIDTH-1:0] o_fetch_rdata,
  input  logic                  i_ls_req,
  input  logic                  i_ls_we,
  input  logic [ADDR_WIDTH-1:0] i_ls_addr,
  input  logic [DATA_WIDTH-1:0] i_ls_wdata,
  output logic                  o_ls_gnt,
  output logic                  o_ls_rvalid,
  output logic [DATA_WIDTH-1:0] o_ls_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  logic       run_q;
  logic [1:0] req;
  logic [1:0] gnt;
  rsp_tag_t   tag_p1;

  // Grants stay off until the first rising edge after reset release.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Bit position matches req_id_e: bit 0 fetch, bit 1 load/store.
  assign req = {i_ls_req, i_fetch_req};

  rr_arbiter_2 u_arb (
    .clk   (i_clock),
    .rst_n (i_reset),
    .en    (run_q),
    .req   (req),
    .gnt   (gnt)
  );

  assign o_fetch_gnt = gnt[0];
  assign o_ls_gnt    = gnt[1];

  // Stage p0: granted command onto the RAM port
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (gnt[0]) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_fetch_addr;
    end else if (gnt[1]) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
    end
  end

  // Stage p1: tag steers the RAM's read data back to the requester
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tag_p1 <= '0;
    end else begin
      tag_p1.valid <= o_mem_en & ~o_mem_we;
      tag_p1.id    <= gnt[1] ? REQ_LS : REQ_FETCH;
    end
  end

  assign o_fetch_rvalid = tag_p1.valid && (tag_p1.id == REQ_FETCH);
  assign o_ls_rvalid    = tag_p1.valid && (tag_p1.id == REQ_LS);
  assign o_fetch_rdata  = o_fetch_rvalid ? i_mem_rdata : '0;
  assign o_ls_rdata     = o_ls_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// model (last-winner fairness, shadow memory, expected response per requester).
module tb_mem_port_arbiter;

  logic        i_clock;
  logic        i_reset;
  logic        i_fetch_req;
  logic [7:0]  i_fetch_addr;
  logic        o_fetch_gnt;
  logic        o_fetch_rvalid;
  logic [15:0] o_fetch_rdata;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [7:0]  i_ls_addr;
  logic [15:0] i_ls_wdata;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [15:0] o_ls_rdata;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;

  mem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_fetch_req    (i_fetch_req),
    .i_fetch_addr   (i_fetch_addr),
    .o_fetch_gnt    (o_fetch_gnt),
    .o_fetch_rvalid (o_fetch_rvalid),
    .o_fetch_rdata  (o_fetch_rdata),
    .i_ls_req       (i_ls_req),
    .i_ls_we        (i_ls_we),
    .i_ls_addr      (i_ls_addr),
    .i_ls_wdata     (i_ls_wdata),
    .o_ls_gnt       (o_ls_gnt),
    .o_ls_rvalid    (o_ls_rvalid),
    .o_ls_rdata     (o_ls_rdata),
    .o_mem_en       (o_mem_en),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Synchronous RAM environment attached to the shared port
  logic [15:0] ram [256];
  always @(posedge i_clock) begin
    if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata     <= ram[o_mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] shadow [256];
  bit          fetch_won_last;
  bit          e_frv, e_lrv;
  logic [15:0] e_fd, e_ld;
  bit          m_gf, m_gl;
  int          wait_f, wait_l;
  bit          obs_lrv;
  logic [15:0] obs_ld;

  task automatic model_reset();
    fetch_won_last = 1'b1;
    e_frv = 1'b0;
    e_lrv = 1'b0;
    wait_f = 0;
    wait_l = 0;
  endtask

  task automatic hold_reset_then_release();
    i_reset = 1'b0;
    model_reset();
    i_fetch_req = 1'b1;
    i_ls_req    = 1'b1;
    repeat (2) begin
      @(negedge i_clock);
      chk("rst_fgnt", o_fetch_gnt, 0);
      chk("rst_lgnt", o_ls_gnt, 0);
      chk("rst_en", o_mem_en, 0);
      chk("rst_we", o_mem_we, 0);
      chk("rst_addr", o_mem_addr, 0);
      chk("rst_wdata", o_mem_wdata, 0);
      chk("rst_frv", o_fetch_rvalid, 0);
      chk("rst_lrv", o_ls_rvalid, 0);
      chk("rst_fd", o_fetch_rdata, 0);
      chk("rst_ld", o_ls_rdata, 0);
    end
    @(posedge i_clock);
    #3 i_reset = 1'b1;
    #1;
    chk("sync_fgnt", o_fetch_gnt, 0);
    chk("sync_lgnt", o_ls_gnt, 0);
    chk("sync_en", o_mem_en, 0);
    @(posedge i_clock);
    #1;
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic step(input bit fr, input logic [7:0] fa, input bit lr, input bit lwe,
                      input logic [7:0] la, input logic [15:0] lwd, input bit rst_mid);
    bit          gf, gl;
    logic [7:0]  ea;
    i_fetch_req  = fr;
    i_fetch_addr = fa;
    i_ls_req     = lr;
    i_ls_we      = lwe;
    i_ls_addr    = la;
    i_ls_wdata   = lwd;
    @(negedge i_clock);
    gf = fr && (!lr || !fetch_won_last);
    gl = lr && !gf;
    ea = gf ? fa : (gl ? la : 8'h00);
    chk("fetch_gnt", o_fetch_gnt, gf);
    chk("ls_gnt", o_ls_gnt, gl);
    chk("mem_en", o_mem_en, gf | gl);
    chk("mem_we", o_mem_we, gl & lwe);
    chk("mem_addr", o_mem_addr, ea);
    if (gl && lwe) chk("mem_wdata", o_mem_wdata, lwd);
    chk("fetch_rvalid", o_fetch_rvalid, e_frv);
    chk("fetch_rdata", o_fetch_rdata, e_frv ? e_fd : 16'h0);
    chk("ls_rvalid", o_ls_rvalid, e_lrv);
    chk("ls_rdata", o_ls_rdata, e_lrv ? e_ld : 16'h0);
    obs_lrv = o_ls_rvalid;
    obs_ld  = o_ls_rdata;
    wait_f = (fr && !o_fetch_gnt) ? wait_f + 1 : 0;
    wait_l = (lr && !o_ls_gnt) ? wait_l + 1 : 0;
    chk("starve_f", 32'(wait_f > 1), 0);
    chk("starve_l", 32'(wait_l > 1), 0);
    if (gf) fetch_won_last = 1'b1;
    if (gl) fetch_won_last = 1'b0;
    if (gl && lwe) shadow[la] = lwd;
    e_frv = gf;
    e_fd  = shadow[fa];
    e_lrv = gl && !lwe;
    e_ld  = shadow[la];
    m_gf = gf;
    m_gl = gl;
    if (rst_mid) begin
      #2;
      hold_reset_then_release();
    end else begin
      @(posedge i_clock);
      #1;
    end
  endtask

  initial begin
    logic [7:0] fa, la;
    bit         fr, lr, lwe;
    logic [15:0] lwd;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'hE210 + 16'(i * 16'h4000);
      shadow[i] = {2'(i) + 2'b11, 14'h2210};
    end
    i_mem_rdata  = 16'h0;
    i_fetch_addr = 8'h00;
    i_ls_we      = 1'b0;
    i_ls_addr    = 8'h00;
    i_ls_wdata   = 16'h0;
    i_reset      = 1'b0;
    hold_reset_then_release();

    // Fetch-only streaming reads
    for (int a = 0; a < 8; a++) step(1, 8'(a), 0, 0, 8'h0, 16'h0, 0);
    step(0, 8'h0, 0, 0, 8'h0, 16'h0, 0);

    // Both requesting continuously: alternation, LS first after reset
    hold_reset_then_release();
    fa = 8'h20;
    la = 8'h40;
    for (int k = 0; k < 12; k++) begin
      step(1, fa, 1, 0, la, 16'h0, 0);
      if (k == 0) chk("ls_first", m_gl, 1);
      if (m_gf) fa++;
      if (m_gl) la++;
    end

    // Store then load same address
    step(0, 8'h0, 1, 1, 8'h10, 16'h1234, 0);
    step(0, 8'h0, 1, 0, 8'h10, 16'h0, 0);
    step(0, 8'h0, 0, 0, 8'h0, 16'h0, 0);
    chk("raw_valid", obs_lrv, 1);
    chk("raw_data", obs_ld, 16'h1234);

    // Idle cycles: pointer must be preserved
    step(1, 8'h3, 0, 0, 8'h0, 16'h0, 0);
    repeat (5) step(0, 8'h0, 0, 0, 8'h0, 16'h0, 0);
    step(1, 8'h4, 1, 0, 8'h5, 16'h0, 0);
    chk("idle_ptr", m_gl, 1);
    step(1, 8'h4, 0, 0, 8'h5, 16'h0, 0);

    // Reset during an in-flight fetch read
    step(1, 8'h7, 0, 0, 8'h0, 16'h0, 1);
    step(1, 8'h8, 1, 0, 8'h9, 16'h0, 0);
    chk("post_rst_ls", m_gl, 1);
    step(1, 8'h8, 0, 0, 8'h9, 16'h0, 0);

    // Randomized traffic with hold-until-granted requesters
    fr = 0; lr = 0; lwe = 0; fa = 0; la = 0; lwd = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!(fr && !m_gf)) begin
        fr = ($urandom_range(0, 3) != 0);
        fa = 8'($urandom_range(0, 255));
      end
      if (!(lr && !m_gl)) begin
        lr  = ($urandom_range(0, 3) != 0);
        lwe = ($urandom_range(0, 2) == 0);
        la  = 8'($urandom_range(0, 15));
        lwd = 16'($urandom);
      end
      step(fr, fa, lr, lwe, la, lwd, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
